// File: rtl/autobaud_pkg.sv
// Shared definitions for the autobaud detector.
//   state_t     : FSM state encoding (legacy-compatible constants)
//   SYNC_EDGES  : falling edges in a 0x55 sync character
//   OVS_SHIFT   : log2 of (8 bit periods * 16x oversampling)
//   ROUND_ADD   : half of 2^OVS_SHIFT, for round-half-up division
package autobaud_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_WAIT_LINE  = 3'd1;
  localparam state_t ST_WAIT_START = 3'd2;
  localparam state_t ST_MEASURE    = 3'd3;
  localparam state_t ST_LOCKED     = 3'd4;
  localparam state_t ST_ERROR      = 3'd5;

  localparam int SYNC_EDGES = 5;
  localparam int OVS_SHIFT  = 7;
  localparam int ROUND_ADD  = 64;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the raw UART line plus falling-edge detector.
//   clk, reset : system clock, synchronous active-high reset
//   rx         : raw asynchronous line
//   rx_s       : synchronized line level
//   fall       : high for one cycle after the synchronized line goes 1 -> 0
module rx_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s,
  output logic fall
);

  logic rx_meta;
  logic rx_prev;

  // Reset to the idle (high) line level so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking, so each stage captures the previous stage's
      // pre-edge value and the chain really is three flops deep.
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall = rx_prev & ~rx_s;

endmodule

// File: rtl/autobaud_detector.sv
// Measures the bit period of a 0x55 sync character and produces the
// 16x-oversampling divisor for the baud tick generator.
//   clk, reset : system clock, synchronous active-high reset
//   rx         : raw asynchronous UART line
//   arm        : one-cycle pulse, starts/restarts detection (wins over edges)
//   baud_dvsr  : divisor, updated only on a successful lock
//   locked     : a measured divisor is held (cleared only by reset)
//   err        : last measurement failed (cleared by arm or reset)
//   done_tick  : one-cycle pulse on lock
module autobaud_detector
  import autobaud_pkg::*;
#(
  parameter int CNT_W        = 20,
  parameter int DVSR_W       = 12,
  parameter int DEFAULT_DVSR = 326,
  parameter int IDLE_CYCLES  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              arm,
  output logic [DVSR_W-1:0] baud_dvsr,
  output logic              locked,
  output logic              err,
  output logic              done_tick
);

  localparam int                IDLE_W   = $clog2(IDLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  T_SAT    = '1;
  localparam logic [CNT_W:0]    DVSR_MAX = (CNT_W+1)'((1 << DVSR_W) - 1);

  logic rx_s;
  logic fall;

  rx_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;
  logic [CNT_W-1:0]  t_cnt;      // cycles since the first falling edge
  logic [CNT_W-1:0]  int_cnt;    // cycles since the latest falling edge
  logic [CNT_W-1:0]  i1;         // first edge-to-edge interval
  logic [2:0]        k;          // index of the latest accepted edge

  // Counters hold "cycles elapsed at the previous edge", so the +1 value is
  // the count that includes the current cycle -- exactly the edge distance.
  logic [CNT_W-1:0] t_inc;
  logic [CNT_W-1:0] int_inc;
  logic [CNT_W-1:0] diff;
  logic [2:0]       k_inc;
  logic             mismatch;
  logic [CNT_W:0]   round_sum;
  logic [CNT_W:0]   dv_full;
  logic             dv_bad;

  assign t_inc     = t_cnt + CNT_W'(1);
  assign int_inc   = int_cnt + CNT_W'(1);
  assign k_inc     = k + 3'd1;
  assign diff      = (int_inc >= i1) ? (int_inc - i1) : (i1 - int_inc);
  assign mismatch  = diff > (i1 >> 2);
  // One extra bit so the rounding add cannot wrap; range-check before
  // truncating to the output width.
  assign round_sum = {1'b0, t_inc} + (CNT_W+1)'(ROUND_ADD);
  assign dv_full   = round_sum >> OVS_SHIFT;
  assign dv_bad    = (dv_full == '0) || (dv_full > DVSR_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idle_cnt  <= '0;
      t_cnt     <= '0;
      int_cnt   <= '0;
      i1        <= '0;
      k         <= '0;
      baud_dvsr <= DVSR_W'(DEFAULT_DVSR);
      locked    <= 1'b0;
      err       <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      // NOTE: default-low assignment first makes done_tick a one-cycle pulse
      // without having to clear it in every branch below.
      done_tick <= 1'b0;
      if (arm) begin
        state    <= ST_WAIT_LINE;
        idle_cnt <= '0;
        err      <= 1'b0;
      end else begin
        case (state)
          ST_WAIT_LINE: begin
            if (rx_s) begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
              if (idle_cnt == IDLE_W'(IDLE_CYCLES - 1)) state <= ST_WAIT_START;
            end else begin
              idle_cnt <= '0;
            end
          end
          ST_WAIT_START: begin
            if (fall) begin
              t_cnt   <= '0;
              int_cnt <= '0;
              k       <= 3'd1;
              state   <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            t_cnt   <= t_inc;
            int_cnt <= int_inc;
            if (t_inc == T_SAT) begin
              state <= ST_ERROR;
              err   <= 1'b1;
            end else if (fall) begin
              k       <= k_inc;
              int_cnt <= '0;
              if (k_inc == 3'd2) begin
                i1 <= int_inc;
              end else if (mismatch) begin
                state <= ST_ERROR;
                err   <= 1'b1;
              end else if (k_inc == 3'(SYNC_EDGES)) begin
                if (dv_bad) begin
                  state <= ST_ERROR;
                  err   <= 1'b1;
                end else begin
                  baud_dvsr <= dv_full[DVSR_W-1:0];
                  locked    <= 1'b1;
                  done_tick <= 1'b1;
                  state     <= ST_LOCKED;
                end
              end
            end
          end
          ST_IDLE, ST_LOCKED, ST_ERROR: ;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_autobaud_detector.sv
// Self-checking bench for autobaud_detector with scaled-down parameters so
// every scenario (including counter saturation) fits in a short run.
module tb_autobaud_detector;

  localparam int CNT_W     = 14;
  localparam int DVSR_W    = 6;
  localparam int DEF_DVSR  = 40;
  localparam int IDLE_CYC  = 64;
  localparam int T_SAT     = (1 << CNT_W) - 1;
  localparam int DVSR_MAX  = (1 << DVSR_W) - 1;

  logic              clk;
  logic              reset;
  logic              rx;
  logic              arm;
  logic [DVSR_W-1:0] baud_dvsr;
  logic              locked;
  logic              err;
  logic              done_tick;

  autobaud_detector #(
    .CNT_W        (CNT_W),
    .DVSR_W       (DVSR_W),
    .DEFAULT_DVSR (DEF_DVSR),
    .IDLE_CYCLES  (IDLE_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .arm       (arm),
    .baud_dvsr (baud_dvsr),
    .locked    (locked),
    .err       (err),
    .done_tick (done_tick)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Works on edge timestamps: the synchronized line is the raw line two
  // clocks late, a start is accepted once IDLE_CYC high samples precede it,
  // and the lock decision is pure arithmetic on the recorded edge times.
  int  edge_n = 0;
  bit  r1 = 1, r2 = 1, r3 = 1;
  bit  hunting = 0, measuring = 0;
  int  run = 0;
  int  edges[$];
  int  m_dvsr = DEF_DVSR;
  bit  m_locked = 0, m_err = 0, m_done = 0;

  always @(posedge clk) begin
    bit s_cur, fall_seen, bad;
    int cnt, dv, iv1, ivk, dif;
    edge_n++;
    s_cur     = r2;
    fall_seen = r3 && !r2;
    m_done    = 0;
    if (reset) begin
      r1 = 1; r2 = 1; r3 = 1;
      hunting = 0; measuring = 0; run = 0;
      edges.delete();
      m_dvsr = DEF_DVSR; m_locked = 0; m_err = 0;
    end else begin
      r3 = r2; r2 = r1; r1 = rx;
      if (arm) begin
        m_err = 0; hunting = 1; measuring = 0; run = 0;
        edges.delete();
      end else if (hunting) begin
        if (fall_seen && run >= IDLE_CYC) begin
          hunting = 0; measuring = 1;
          edges.delete();
          edges.push_back(edge_n);
        end else begin
          run = s_cur ? run + 1 : 0;
        end
      end else if (measuring) begin
        cnt = edge_n - edges[0];
        bad = 0;
        if (cnt >= T_SAT) begin
          bad = 1;
        end else if (fall_seen) begin
          edges.push_back(edge_n);
          if (edges.size() >= 3) begin
            iv1 = edges[1] - edges[0];
            ivk = edges[edges.size()-1] - edges[edges.size()-2];
            dif = (ivk > iv1) ? ivk - iv1 : iv1 - ivk;
            if (dif > iv1 / 4) bad = 1;
          end
          if (!bad && edges.size() == 5) begin
            dv = (cnt + 64) / 128;
            if (dv == 0 || dv > DVSR_MAX) begin
              bad = 1;
            end else begin
              measuring = 0;
              m_dvsr = dv; m_locked = 1; m_done = 1;
            end
          end
        end
        if (bad) begin
          measuring = 0;
          m_err = 1;
        end
      end
    end
  end

  // One compare process, every cycle once reset has been applied.
  always @(negedge clk) begin
    if (done_tick === 1'b1) done_cnt++;
    if (chk_en) begin
      check("cyc_baud_dvsr", baud_dvsr, m_dvsr);
      check("cyc_locked", locked, m_locked);
      check("cyc_err", err, m_err);
      check("cyc_done_tick", done_tick, m_done);
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold_rx(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Falling edges separated by iv[0..3]; each low lasts p cycles.
  // With all intervals 2p this is a 0x55 frame at p cycles per bit.
  task automatic send_train(input int p, input int iv[4], input int n_edges);
    for (int e = 0; e < n_edges; e++) begin
      hold_rx(1'b0, p);
      if (e < n_edges - 1) hold_rx(1'b1, iv[e] - p);
    end
    hold_rx(1'b1, p);
  endtask

  task automatic send_55(input int p);
    int iv[4];
    iv = '{2*p, 2*p, 2*p, 2*p};
    send_train(p, iv, 5);
  endtask

  task automatic send_byte(input logic [7:0] b, input int p);
    hold_rx(1'b0, p);
    for (int i = 0; i < 8; i++) hold_rx(b[i], p);
    hold_rx(1'b1, p);
  endtask

  task automatic armed_55(input int p);
    pulse_arm();
    hold_rx(1'b1, 100);
    send_55(p);
    hold_rx(1'b1, 10);
  endtask

  initial begin
    int iv[4];
    int p, idle, d0;
    rx = 1'b1; arm = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    check("rst_dvsr", baud_dvsr, DEF_DVSR);
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_done", done_tick, 0);
    hold_rx(1'b1, 5);

    // Wrong character 0x33: I1 = 3p, I2 = 4p -> mismatch at the third edge.
    pulse_arm();
    hold_rx(1'b1, 100);
    send_byte(8'h33, 100);
    hold_rx(1'b1, 10);
    check("x33_err", err, 1);
    check("x33_dvsr", baud_dvsr, DEF_DVSR);
    check("x33_locked", locked, 0);
    pulse_arm();
    check("arm_clears_err", err, 0);

    // p=100: T=800, (800+64)>>7 = 6, exactly one done pulse.
    d0 = done_cnt;
    hold_rx(1'b1, 100);
    send_55(100);
    hold_rx(1'b1, 10);
    check("p100_dvsr", baud_dvsr, 6);
    check("p100_model_dvsr", m_dvsr, 6);
    check("p100_locked", locked, 1);
    check("p100_done_count", done_cnt - d0, 1);

    // Divisor boundaries: p=8 -> 1, p=7 -> 0 (error), p=1015 -> 63, p=1016 -> 64 (error).
    armed_55(8);
    check("p8_dvsr", baud_dvsr, 1);
    armed_55(7);
    check("p7_err", err, 1);
    check("p7_dvsr_kept", baud_dvsr, 1);
    armed_55(1015);
    check("p1015_dvsr", baud_dvsr, 63);
    armed_55(1016);
    check("p1016_err", err, 1);
    check("p1016_dvsr_kept", baud_dvsr, 63);
    check("p1016_locked_kept", locked, 1);

    // arm after the third edge restarts detection; a clean p=50 then locks to 3.
    pulse_arm();
    hold_rx(1'b1, 100);
    iv = '{200, 200, 200, 200};
    send_train(100, iv, 3);
    pulse_arm();
    check("midarm_err", err, 0);
    hold_rx(1'b1, 100);
    send_55(50);
    hold_rx(1'b1, 10);
    check("midarm_dvsr", baud_dvsr, 3);

    // reset mid-measurement returns everything to reset values.
    pulse_arm();
    hold_rx(1'b1, 100);
    send_train(100, iv, 3);
    pulse_reset();
    check("midrst_dvsr", baud_dvsr, DEF_DVSR);
    check("midrst_locked", locked, 0);
    check("midrst_err", err, 0);
    armed_55(50);
    check("after_rst_dvsr", baud_dvsr, 3);

    // Randomized frames: random bit period, interval jitter around the
    // tolerance limit, idle times straddling IDLE_CYC, occasional glitch.
    for (int n = 0; n < 10; n++) begin
      p = $urandom_range(8, 200);
      for (int e = 0; e < 4; e++) begin
        if ($urandom_range(0, 2) == 0)
          iv[e] = 2*p + $urandom_range(0, p + 6) - (p/2 + 3);
        else
          iv[e] = 2*p;
      end
      idle = $urandom_range(IDLE_CYC - 8, IDLE_CYC + 40);
      pulse_arm();
      if ($urandom_range(0, 3) == 0) begin
        hold_rx(1'b1, 30);
        hold_rx(1'b0, 3);
      end
      hold_rx(1'b1, idle);
      send_train(p, iv, 5);
      hold_rx(1'b1, 20);
    end

    // Stuck line: one falling edge then low forever -> saturation error.
    pulse_arm();
    hold_rx(1'b1, 100);
    hold_rx(1'b0, T_SAT + 10);
    check("stuck_err", err, 1);
    hold_rx(1'b1, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
